// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable multi-channel clock divider.
// Holds the per-channel state encoding and the minimum legal ratio.
package prog_clk_div_pkg;

  // Per-channel run state. STOP_PEND keeps counting until the period ends so
  // that a disable never truncates a high phase.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } ch_state_e;

  // Smallest ratio that still yields a clock (one high, one low cycle).
  localparam int unsigned MIN_DIV = 2;

endpackage : prog_clk_div_pkg

// File: rtl/prog_clk_div_ch.sv
// One channel of the programmable clock divider.
// Runs a modulo-N counter and drives a registered divided clock that is high
// for the first floor(N/2) counts of each period. A new ratio/phase is held in
// a pending shadow and applied only at a period boundary (or immediately when
// the channel is idle), so the output never glitches on reconfiguration.
// Ports:
//   clk_i       reference clock, posedge
//   rst_ni      asynchronous active-low reset
//   en_i        run enable (level)
//   div_i       requested ratio N (clamped to >= 2 on capture)
//   phase_i     requested start count (clamped to <= N-1 on capture)
//   load_i      capture div_i/phase_i into the pending shadow
//   sync_i      realign a running channel to its phase
//   clk_o       divided clock
//   active_o    channel is in RUN or STOP_PEND
//   cfg_pend_o  captured configuration not yet applied
module prog_clk_div_ch
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned DivWidth = 8,
  parameter int unsigned DefDiv   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic [DivWidth-1:0] phase_i,
  input  logic                load_i,
  input  logic                sync_i,
  output logic                clk_o,
  output logic                active_o,
  output logic                cfg_pend_o
);

  localparam logic [DivWidth-1:0] MinDivW = DivWidth'(MIN_DIV);
  localparam logic [DivWidth-1:0] DefDivW = DivWidth'(DefDiv);
  localparam logic [DivWidth-1:0] OneW    = DivWidth'(1);

  function automatic logic [DivWidth-1:0] clamp_div(input logic [DivWidth-1:0] d);
    return (d < MinDivW) ? MinDivW : d;
  endfunction

  function automatic logic [DivWidth-1:0] clamp_phase(input logic [DivWidth-1:0] ph,
                                                      input logic [DivWidth-1:0] n);
    return (ph >= n) ? (n - OneW) : ph;
  endfunction

  ch_state_e           state_q, state_d;
  logic [DivWidth-1:0] cnt_q, cnt_d;
  logic [DivWidth-1:0] n_q, n_d;
  logic [DivWidth-1:0] ph_q, ph_d;
  logic [DivWidth-1:0] pend_n_q, pend_n_d;
  logic [DivWidth-1:0] pend_ph_q, pend_ph_d;
  logic                pend_q, pend_d;
  logic                clk_q, clk_d;

  logic                terminal;
  logic                high;
  logic                apply;
  logic [DivWidth-1:0] cap_n;

  assign terminal = (cnt_q == (n_q - OneW));
  assign high     = (cnt_q < (n_q >> 1));
  assign cap_n    = clamp_div(div_i);
  // Idle channels take pending config right away; running ones wait for the
  // end of the current period so the old ratio completes untouched.
  assign apply    = pend_q && ((state_q == ST_IDLE) || terminal);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    ph_d      = ph_q;
    pend_n_d  = pend_n_q;
    pend_ph_d = pend_ph_q;
    pend_d    = pend_q;
    clk_d     = clk_q;

    if (apply) begin
      n_d    = pend_n_q;
      ph_d   = pend_ph_q;
      pend_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        clk_d = 1'b0;
        if (en_i) begin
          state_d = ST_RUN;
          // Start phase comes from the applied config, never from pending.
          cnt_d   = ph_q;
        end
      end
      ST_RUN, ST_STOP_PEND: begin
        clk_d = high;
        cnt_d = terminal ? '0 : (cnt_q + OneW);
        // On an apply edge the realignment uses the newly applied phase.
        if (sync_i) cnt_d = apply ? pend_ph_q : ph_q;
        if (en_i) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_STOP_PEND) && terminal) begin
          // Output is already low at the last count, so stopping here is clean.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clk_d   = 1'b0;
      end
    endcase

    // A capture on an apply edge lands after the old pending has been taken.
    if (load_i) begin
      pend_n_d  = cap_n;
      pend_ph_d = clamp_phase(phase_i, cap_n);
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      n_q       <= DefDivW;
      ph_q      <= '0;
      pend_n_q  <= DefDivW;
      pend_ph_q <= '0;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      ph_q      <= ph_d;
      pend_n_q  <= pend_n_d;
      pend_ph_q <= pend_ph_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
    end
  end

  assign clk_o      = clk_q;
  assign active_o   = (state_q != ST_IDLE);
  assign cfg_pend_o = pend_q;

endmodule : prog_clk_div_ch

// File: rtl/prog_clk_div.sv
// Multi-channel programmable integer clock divider.
// Unpacks the per-channel ratio/phase buses and broadcasts load/sync to
// NumCh independent divider channels.
// Ports:
//   i_clk_ref   reference clock
//   i_rst_n     asynchronous active-low reset
//   i_en        per-channel run enable
//   i_div       per-channel ratio, ch k at [k*DivWidth +: DivWidth]
//   i_phase     per-channel start count, same packing
//   i_load      capture i_div/i_phase of all channels into pending
//   i_sync      realign all running channels to their phase
//   o_clk       divided clocks
//   o_active    channel in RUN or STOP_PEND
//   o_cfg_pend  captured config not yet applied
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NumCh    = 4,
  parameter int unsigned DivWidth = 8,
  parameter int unsigned DefDiv   = 4
) (
  input  logic                      i_clk_ref,
  input  logic                      i_rst_n,
  input  logic [NumCh-1:0]          i_en,
  input  logic [NumCh*DivWidth-1:0] i_div,
  input  logic [NumCh*DivWidth-1:0] i_phase,
  input  logic                      i_load,
  input  logic                      i_sync,
  output logic [NumCh-1:0]          o_clk,
  output logic [NumCh-1:0]          o_active,
  output logic [NumCh-1:0]          o_cfg_pend
);

  for (genvar k = 0; k < NumCh; k++) begin : g_ch
    prog_clk_div_ch #(
      .DivWidth (DivWidth),
      .DefDiv   (DefDiv)
    ) u_ch (
      .clk_i      (i_clk_ref),
      .rst_ni     (i_rst_n),
      .en_i       (i_en[k]),
      .div_i      (i_div[k*DivWidth +: DivWidth]),
      .phase_i    (i_phase[k*DivWidth +: DivWidth]),
      .load_i     (i_load),
      .sync_i     (i_sync),
      .clk_o      (o_clk[k]),
      .active_o   (o_active[k]),
      .cfg_pend_o (o_cfg_pend[k])
    );
  end

endmodule : prog_clk_div
